// File: rtl/maquina_maluca.sv
// Passive checker for the maquina_maluca coffee FSM: validates every observed
// transition, measures clean brew runs and latches the first error cause.
module maquina_maluca_monitor #(
  parameter int MAX_DWELL  = 16,
  parameter int MAX_REFILL = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       state,
  input  logic             clear_err,
  output logic             run_active,
  output logic             done,
  output logic             erro,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] run_cycles,
  output logic [3:0]       refill_count,
  output logic [7:0]       runs_ok
);

  localparam int DW_W = $clog2(MAX_DWELL + 1);

  typedef enum logic [1:0] {M_WAIT_IDLE, M_IDLE, M_RUN, M_ERROR} mstate_t;

  mstate_t          mst;
  logic [3:0]       prev_state;
  logic [DW_W-1:0]  dwell;
  logic [3:0]       refill;
  logic             start_seen;
  logic [CNT_W-1:0] run_cnt;

  logic            ill, changed, bad_trans, legal;
  logic [DW_W-1:0] dwell_nx;
  logic [3:0]      refill_nx;
  logic [2:0]      idle_code, run_code;

  always_comb begin
    legal = 1'b0;
    case (prev_state)
      4'd1:    legal = (state == 4'd2);
      4'd2:    legal = (state == 4'd3);
      4'd3:    legal = (state == 4'd4) || (state == 4'd5);
      4'd4:    legal = (state == 4'd3);
      4'd5:    legal = (state == 4'd6);
      4'd6:    legal = (state == 4'd7);
      4'd7:    legal = (state == 4'd8);
      4'd8:    legal = (state == 4'd9);
      4'd9:    legal = (state == 4'd1);
      default: legal = 1'b0;
    endcase
    ill       = (state == 4'd0) || (state > 4'd9);
    changed   = (state != prev_state);
    bad_trans = changed && !legal;
    dwell_nx  = changed ? DW_W'(1) : dwell + DW_W'(1);
    refill_nx = refill + 4'((changed && state == 4'd4) ? 1 : 0);

    // Lowest code wins when several causes hit on the same sample.
    idle_code = 3'd0;
    if (ill)                                 idle_code = 3'd1;
    else if (bad_trans)                      idle_code = 3'd2;
    else if (state == 4'd2 && !start_seen)   idle_code = 3'd3;

    run_code = 3'd0;
    if (ill)                                 run_code = 3'd1;
    else if (bad_trans)                      run_code = 3'd2;
    else if (refill_nx > 4'(MAX_REFILL))     run_code = 3'd4;
    else if (dwell_nx >= DW_W'(MAX_DWELL))   run_code = 3'd5;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mst          <= M_WAIT_IDLE;
      prev_state   <= 4'd0;
      dwell        <= '0;
      refill       <= '0;
      start_seen   <= 1'b0;
      run_cnt      <= '0;
      run_active   <= 1'b0;
      done         <= 1'b0;
      erro         <= 1'b0;
      err_code     <= 3'd0;
      run_cycles   <= '0;
      refill_count <= '0;
      runs_ok      <= '0;
    end else begin
      prev_state <= state;
      done       <= 1'b0;
      case (mst)
        M_WAIT_IDLE: begin
          if (state == 4'd1) begin
            mst        <= M_IDLE;
            start_seen <= start;
          end
        end
        M_IDLE: begin
          if (idle_code != 3'd0) begin
            mst        <= M_ERROR;
            erro       <= 1'b1;
            err_code   <= idle_code;
            start_seen <= 1'b0;
          end else if (changed) begin
            // Only a started 1->2 survives the checks above.
            mst        <= M_RUN;
            run_cnt    <= CNT_W'(1);
            refill     <= 4'd0;
            dwell      <= DW_W'(1);
            start_seen <= 1'b0;
            run_active <= 1'b1;
          end else if (start) begin
            start_seen <= 1'b1;
          end
        end
        M_RUN: begin
          if (run_code != 3'd0) begin
            mst        <= M_ERROR;
            erro       <= 1'b1;
            err_code   <= run_code;
            run_active <= 1'b0;
          end else if (prev_state == 4'd9 && state == 4'd1) begin
            mst          <= M_IDLE;
            done         <= 1'b1;
            run_active   <= 1'b0;
            run_cycles   <= run_cnt;
            refill_count <= refill;
            if (runs_ok != 8'hff) runs_ok <= runs_ok + 8'd1;
          end else begin
            run_cnt <= run_cnt + CNT_W'(changed ? 1 : 0);
            dwell   <= dwell_nx;
            refill  <= refill_nx;
          end
        end
        M_ERROR: begin
          if (clear_err) begin
            mst      <= M_WAIT_IDLE;
            erro     <= 1'b0;
            err_code <= 3'd0;
          end
        end
        default: mst <= M_WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maquina_maluca_monitor.sv
// Directed bench for maquina_maluca_monitor: vector table plus corner sequences.
module tb_maquina_maluca_monitor;

  logic        clk = 1'b0;
  logic        rst, start, clear_err;
  logic [3:0]  state;
  logic        run_active, done, erro;
  logic [2:0]  err_code;
  logic [15:0] run_cycles;
  logic [3:0]  refill_count;
  logic [7:0]  runs_ok;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  maquina_maluca_monitor #(.MAX_DWELL(16), .MAX_REFILL(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .state(state), .clear_err(clear_err),
    .run_active(run_active), .done(done), .erro(erro), .err_code(err_code),
    .run_cycles(run_cycles), .refill_count(refill_count), .runs_ok(runs_ok)
  );

  typedef struct {
    logic        rst, start;
    logic [3:0]  state;
    logic        clr;
    logic        ra, dn, er;
    logic [2:0]  code;
    logic [15:0] rc;
    logic [3:0]  rf;
    logic [7:0]  ok;
  } vec_t;

  vec_t vq[$];
  int   nom[9] = '{2, 3, 4, 3, 5, 6, 7, 8, 9};

  task automatic add(input logic r, input logic s, input logic [3:0] st, input logic c,
                     input logic ra, input logic dn, input logic er, input logic [2:0] code,
                     input logic [15:0] rc, input logic [3:0] rf, input logic [7:0] ok);
    vec_t v;
    v.rst = r; v.start = s; v.state = st; v.clr = c;
    v.ra = ra; v.dn = dn; v.er = er; v.code = code; v.rc = rc; v.rf = rf; v.ok = ok;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [3:0] st, input logic c);
    rst = r; start = s; state = st; clear_err = c;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] outs();
    return 64'({run_active, done, erro, err_code, run_cycles, refill_count, runs_ok});
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; state = 4'd1; clear_err = 1'b0;

    // Clean nominal run with one refill.
    add(1,0,1,0, 0,0,0,0,0,0,0);
    add(1,0,1,0, 0,0,0,0,0,0,0);
    add(0,0,1,0, 0,0,0,0,0,0,0);
    add(0,1,1,0, 0,0,0,0,0,0,0);
    add(0,0,1,0, 0,0,0,0,0,0,0);
    foreach (nom[i]) add(0,0,4'(nom[i]),0, 1,0,0,0,0,0,0);
    add(0,0,1,0, 0,1,0,0,9,1,1);
    add(0,0,1,0, 0,0,0,0,9,1,1);
    // Every state held three samples: still 9 changes, no dwell error.
    add(0,1,1,0, 0,0,0,0,9,1,1);
    foreach (nom[i]) for (int k = 0; k < 3; k++) add(0,0,4'(nom[i]),0, 1,0,0,0,9,1,1);
    add(0,0,1,0, 0,1,0,0,9,1,2);
    add(0,0,1,0, 0,0,0,0,9,1,2);
    // Unprompted start, clear, then a clean run.
    add(1,0,1,0, 0,0,0,0,0,0,0);
    add(1,0,1,0, 0,0,0,0,0,0,0);
    add(0,0,1,0, 0,0,0,0,0,0,0);
    add(0,0,2,0, 0,0,1,3,0,0,0);
    add(0,0,2,0, 0,0,1,3,0,0,0);
    add(0,0,2,1, 0,0,0,0,0,0,0);
    add(0,0,1,0, 0,0,0,0,0,0,0);
    add(0,1,1,0, 0,0,0,0,0,0,0);
    foreach (nom[i]) add(0,0,4'(nom[i]),0, 1,0,0,0,0,0,0);
    add(0,0,1,0, 0,1,0,0,9,1,1);
    // Illegal 5->7, later 9->1 must not produce done.
    add(0,1,1,0, 0,0,0,0,9,1,1);
    add(0,0,2,0, 1,0,0,0,9,1,1);
    add(0,0,3,0, 1,0,0,0,9,1,1);
    add(0,0,5,0, 1,0,0,0,9,1,1);
    add(0,0,7,0, 0,0,1,2,9,1,1);
    add(0,0,8,0, 0,0,1,2,9,1,1);
    add(0,0,9,0, 0,0,1,2,9,1,1);
    add(0,0,1,0, 0,0,1,2,9,1,1);
    add(0,0,1,1, 0,0,0,0,9,1,1);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].start, vq[i].state, vq[i].clr);
      chk($sformatf("vec%0d", i), outs(),
          64'({vq[i].ra, vq[i].dn, vq[i].er, vq[i].code, vq[i].rc, vq[i].rf, vq[i].ok}));
    end

    // Fourth refill entry overflows.
    step(1,0,1,0); step(1,0,1,0);
    chk("reset_outs", outs(), 64'd0);
    step(0,0,1,0); step(0,1,1,0);
    step(0,0,2,0); step(0,0,3,0);
    for (int k = 0; k < 3; k++) begin step(0,0,4,0); step(0,0,3,0); end
    chk("refill3_ok", 64'(erro), 64'd0);
    chk("refill3_active", 64'(run_active), 64'd1);
    step(0,0,4,0);
    chk("refill_err", 64'(erro), 64'd1);
    chk("refill_code", 64'(err_code), 64'd4);
    chk("refill_ra", 64'(run_active), 64'd0);

    // Code 12 mid-run: illegal value outranks illegal transition.
    step(0,0,1,1);
    chk("clear_erro", 64'(erro), 64'd0);
    step(0,0,1,0); step(0,1,1,0);
    step(0,0,2,0); step(0,0,3,0);
    step(0,0,12,0);
    chk("illegal_code", 64'(err_code), 64'd1);

    // Dwell: 15 samples in state 6 tolerated, 16th flags.
    step(0,0,1,1); step(0,0,1,0); step(0,1,1,0);
    step(0,0,2,0); step(0,0,3,0); step(0,0,5,0); step(0,0,6,0);
    repeat (14) step(0,0,6,0);
    chk("dwell15_ok", 64'(erro), 64'd0);
    step(0,0,6,0);
    chk("dwell16_erro", 64'(erro), 64'd1);
    chk("dwell16_code", 64'(err_code), 64'd5);

    // Clean run, single-cycle done, then reset mid-run.
    step(0,0,1,1); step(0,0,1,0); step(0,1,1,0);
    foreach (nom[i]) step(0, (i == 3), 4'(nom[i]), 0);
    step(0,0,1,0);
    chk("done_pulse", 64'(done), 64'd1);
    chk("runs_ok_1", 64'(runs_ok), 64'd1);
    step(0,0,1,0);
    chk("done_once", 64'(done), 64'd0);
    step(0,1,1,0); step(0,0,2,0); step(0,0,3,0);
    chk("midrun_active", 64'(run_active), 64'd1);
    step(1,0,4,0);
    chk("midrun_rst", outs(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
